// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding,
// parameter defaults and the instruction word width.
package fetch_queue_pkg;
  localparam int unsigned FQ_DEPTH    = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
  localparam int unsigned INST_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fq_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instruction} pairs, with flush.
// When empty, dout keeps the last head value that was presented.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [WIDTH-1:0] hold;
  logic             empty, do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      // Track the visible head so the outputs freeze once the queue drains.
      if (!empty) hold <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (do_push && !do_pop)      count <= count + CNT_ONE;
        else if (do_pop && !do_push) count <= count - CNT_ONE;
      end
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding memory requester with
// redirect/drop handling, feeding a small instruction queue toward decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_state_e          state, nstate;
  logic [31:0]        fptr, req_pc;
  logic [CW-1:0]      count;
  logic               grant, push, pop;
  logic [2*INST_W-1:0] head;

  // Nothing is outstanding in IDLE, so the credit check reduces to count < DEPTH.
  assign imem_req   = reset && (state == ST_IDLE) && !redirect_valid && (count < FULL);
  assign imem_addr  = fptr;
  assign grant      = imem_req && imem_gnt;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst_pc    = head[2*INST_W-1:INST_W];
  assign inst       = head[INST_W-1:0];

  always_comb begin
    nstate = state;
    push   = 1'b0;
    case (state)
      ST_IDLE: if (grant) nstate = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          nstate = ST_IDLE;
          push   = !redirect_valid;
        end else if (redirect_valid) begin
          nstate = ST_DROP;
        end
      end
      ST_DROP: if (imem_rvalid) nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fptr   <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fptr <= {redirect_pc[31:2], 2'b00};
    end else if (grant) begin
      req_pc <= fptr;
      fptr   <= fptr + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*INST_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({req_pc, imem_rdata}),
    .dout  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model state: queue contents as {pc, word}
  logic [63:0] mq[$];
  bit          m_out, m_drop;
  logic [31:0] m_ptr, m_pc;
  logic [63:0] m_last;

  // Memory responder state (stimulus side)
  bit          mem_pending = 0;
  logic [31:0] mem_addr_pend = '0;
  int          grants = 0;

  always @(negedge clk) begin
    logic        e_req, e_valid, e_pop, e_grant;
    logic [63:0] e_head;
    if (!reset) begin
      mq.delete();
      m_out  = 0;
      m_drop = 0;
      m_ptr  = RESET_PC;
      m_pc   = RESET_PC;
      m_last = '0;
    end
    e_req   = reset && !m_out && (mq.size() < DEPTH) && !redirect_valid;
    e_valid = (mq.size() != 0);
    e_head  = e_valid ? mq[0] : m_last;
    check("imem_req",   32'(imem_req),   32'(e_req));
    check("imem_addr",  imem_addr,       m_ptr);
    check("inst_valid", 32'(inst_valid), 32'(e_valid));
    check("inst",       inst,            e_head[31:0]);
    check("inst_pc",    inst_pc,         e_head[63:32]);
    if (reset) begin
      e_pop   = e_valid && inst_ready && !redirect_valid;
      e_grant = e_req && imem_gnt;
      if (e_valid) m_last = mq[0];
      if (redirect_valid) begin
        mq.delete();
        m_ptr = {redirect_pc[31:2], 2'b00};
        if (m_out) begin
          if (imem_rvalid) begin m_out = 0; m_drop = 0; end
          else m_drop = 1;
        end
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (m_out && imem_rvalid) begin
          if (!m_drop) mq.push_back({m_pc, imem_rdata});
          m_out  = 0;
          m_drop = 0;
        end
        if (e_grant) begin
          m_out  = 1;
          m_drop = 0;
          m_pc   = m_ptr;
          m_ptr  = m_ptr + 32'd4;
        end
      end
    end
    if (imem_rvalid) mem_pending = 0;
    if (imem_req && imem_gnt) begin
      mem_pending   = 1;
      mem_addr_pend = imem_addr;
      grants++;
    end
  end

  bit          auto_mem = 0;
  bit          rd_tag = 0;
  int unsigned p_gnt = 100, p_rv = 100;

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_gnt    = ($urandom_range(99) < p_gnt);
      imem_rvalid = mem_pending && ($urandom_range(99) < p_rv);
      imem_rdata  = rd_tag ? (mem_addr_pend ^ 32'hC0DE_0000) : $urandom();
    end
  endtask

  task automatic mem(input logic g, input logic rv, input logic [31:0] d);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = d;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Two entries queued (pc 0 and 4) and a request for 8 waiting on its response.
  task automatic fill2_wait8(input string tag);
    mem(1, 0, '0);            step();
    mem(0, 1, 32'h1111_0000); step();
    mem(1, 0, '0);            step();
    mem(0, 1, 32'h2222_0004); step();
    mem(1, 0, '0); #1;
    check({tag, "_addr8"}, imem_addr, 32'h0000_0008);
    step();
  endtask

  logic [31:0] exp_pc   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] exp_inst [4] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};

  initial begin
    int g0;
    bit ok;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0;
    mem(0, 0, '0);

    // Streaming fetch with an always-granting, always-responding memory
    auto_mem = 1; rd_tag = 1; p_gnt = 100; p_rv = 100; inst_ready = 1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int unsigned i = 0; i < 10; i++) begin
        #1;
        if (inst_valid) begin ok = 1; break; end
        step();
      end
      check("stream_valid", 32'(ok), 32'd1);
      check("stream_pc", inst_pc, exp_pc[k]);
      check("stream_inst", inst, exp_inst[k]);
      step();
    end

    // Credit limit with decode stalled
    inst_ready = 0;
    do_reset();
    g0 = grants;
    repeat (20) step();
    #1;
    check("credit_grants", 32'(grants - g0), 32'd4);
    check("credit_req_low", 32'(imem_req), 32'd0);
    inst_ready = 1;
    step();
    inst_ready = 0;
    repeat (20) step();
    #1;
    check("credit_one_more", 32'(grants - g0), 32'd5);
    check("credit_req_low2", 32'(imem_req), 32'd0);

    // Redirect while the request to 8 is pending
    auto_mem = 0; rd_tag = 0; mem(0, 0, '0); inst_ready = 0;
    do_reset();
    fill2_wait8("rdw");
    mem(0, 0, '0); redirect_valid = 1; redirect_pc = 32'h0000_0103; #1;
    check("rdw_head_pc", inst_pc, 32'h0);
    check("rdw_head", inst, 32'h1111_0000);
    step();
    redirect_valid = 0; mem(0, 1, 32'hDEAD_0008); #1;
    check("rdw_flushed", 32'(inst_valid), 32'd0);
    check("rdw_drop_noreq", 32'(imem_req), 32'd0);
    step();
    mem(0, 0, '0); #1;
    check("rdw_req", 32'(imem_req), 32'd1);
    check("rdw_addr", imem_addr, 32'h0000_0100);
    check("rdw_empty", 32'(inst_valid), 32'd0);
    step();

    // Redirect coinciding with response and pop, two entries queued
    do_reset();
    fill2_wait8("rrp");
    mem(0, 1, 32'hBAD0_0008); redirect_valid = 1; redirect_pc = 32'h0000_2000;
    inst_ready = 1; #1;
    check("rrp_valid_before", 32'(inst_valid), 32'd1);
    step();
    redirect_valid = 0; inst_ready = 0; mem(0, 0, '0); #1;
    check("rrp_flushed", 32'(inst_valid), 32'd0);
    check("rrp_req", 32'(imem_req), 32'd1);
    check("rrp_addr", imem_addr, 32'h0000_2000);
    step();
    #1;
    check("rrp_no_write", 32'(inst_valid), 32'd0);

    // Fetch pointer wrap at the top of the address space
    do_reset();
    mem(0, 0, '0); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0; mem(1, 0, '0); #1;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("wrap_req_top", 32'(imem_req), 32'd1);
    step();
    mem(0, 1, 32'h7777_0000); step();
    mem(1, 0, '0); #1;
    check("wrap_addr_zero", imem_addr, 32'h0000_0000);
    check("wrap_head_pc", inst_pc, 32'hFFFF_FFFC);
    step();
    mem(0, 1, 32'h7777_0004); step();
    mem(0, 0, '0);

    // Reset while waiting, then a late response after release
    do_reset();
    redirect_valid = 1; redirect_pc = 32'h0000_0500;
    step();
    redirect_valid = 0; mem(1, 0, '0); #1;
    check("rst_addr500", imem_addr, 32'h0000_0500);
    step();
    reset = 0; mem(0, 0, '0); #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    step();
    step();
    reset = 1; mem(0, 1, 32'hAAAA_0500); #1;
    check("late_req", 32'(imem_req), 32'd1);
    check("late_addr", imem_addr, RESET_PC);
    step();
    mem(0, 0, '0); #1;
    check("late_no_write", 32'(inst_valid), 32'd0);
    check("late_addr2", imem_addr, RESET_PC);
    step();

    // Random traffic against the model
    auto_mem = 1; rd_tag = 0; p_gnt = 70; p_rv = 60;
    for (int n = 0; n < 3000; n++) begin
      step();
      reset          = ($urandom_range(199) != 0);
      redirect_valid = ($urandom_range(99) < 6);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      inst_ready     = ($urandom_range(99) < 60);
    end
    step();
    reset = 1; redirect_valid = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of instruction queue entries (power of two, minimum 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the fetch address loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port redirect_valid, input, 1 bit: a new fetch address from the PC register stage (branch or jump).
REQ-006 SHALL have port redirect_pc, input, 32 bits: the redirect target.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 SHALL have port imem_addr, output, 32 bits: the request address, word aligned.
REQ-009 SHALL have port imem_gnt, input, 1 bit: the request is accepted this cycle.
REQ-010 SHALL have port imem_rvalid, input, 1 bit: the read data is valid this cycle.
REQ-011 SHALL have port imem_rdata, input, 32 bits: the instruction word.
REQ-012 SHALL have port inst_valid, output, 1 bit: the queue head is valid toward decode.
REQ-013 SHALL have port inst_ready, input, 1 bit: decode accepts the head.
REQ-014 SHALL have port inst, output, 32 bits: the head instruction.
REQ-015 SHALL have port inst_pc, output, 32 bits: the address of the head instruction.

Function
REQ-016 SHALL keep an internal 32-bit fetch pointer.
- It increments by 4 on each imem_gnt.
- It wraps from 32'hFFFF_FFFC to 0.
REQ-017 SHALL implement a three-state FSM:
- IDLE: no request outstanding.
- WAIT: a request is granted and its response is pending.
- DROP: a granted response is pending and will be discarded.
REQ-018 In IDLE, SHALL assert imem_req when (queue count + outstanding) < DEPTH and redirect_valid is low.
- imem_req and imem_addr stay stable until imem_gnt.
- The imem_gnt cycle moves IDLE to WAIT.
REQ-019 In WAIT, SHALL write {fetch address, imem_rdata} into the queue tail when imem_rvalid is high, then return to IDLE.
- The entry becomes visible on inst_valid the next cycle (one-cycle latency).
REQ-020 SHALL allow at most one outstanding request; imem_req is low in WAIT and DROP.
REQ-021 SHALL pop the head when inst_valid and inst_ready are both high.
- A push and a pop in the same cycle SHALL both take effect, and the count stays unchanged.
REQ-022 SHALL never overflow: the credit rule in REQ-018 guarantees a free slot for every accepted request.
REQ-023 On redirect_valid, SHALL in the same cycle:
- flush all queue entries (inst_valid low the next cycle);
- load the fetch pointer with {redirect_pc[31:2], 2'b00};
- move WAIT to DROP; IDLE stays IDLE.
REQ-024 An imem_req that is pending but not yet granted SHALL be withdrawn the cycle redirect_valid is high.
- The new address is requested no earlier than the next cycle.
REQ-025 In DROP, imem_rvalid SHALL be consumed without a queue write, then the FSM returns to IDLE.
- redirect_valid in DROP stays in DROP and reloads the pointer.
REQ-026 When redirect_valid and imem_rvalid occur in the same WAIT cycle, the response SHALL be discarded and the FSM goes to IDLE.
REQ-027 When redirect_valid and a pop occur in the same cycle, the flush SHALL take priority.
REQ-028 When the queue is empty, inst and inst_pc SHALL hold their last value; they are don't-care to decode.

Reset
REQ-029 While reset is low, the block SHALL immediately hold:
- state IDLE, fetch pointer = RESET_PC, queue empty;
- imem_req = 0, inst_valid = 0, imem_addr = RESET_PC, inst = 0, inst_pc = 0.
REQ-030 Reset asserted mid-request SHALL abandon that request.
- Any imem_rvalid from it after reset release is ignored, because the FSM is in IDLE.
REQ-031 The first imem_req SHALL assert in the first clock cycle after reset deasserts.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state encoding (IDLE/WAIT/DROP);
- DEPTH and RESET_PC defaults;
- the instruction word width constant (32).
REQ-033 The queue storage SHALL be one sub-module, fetch_fifo: a synchronous DEPTH x 64-bit FIFO with push, pop, flush, count and an asynchronous active-low reset.
REQ-034 FSM, credit logic and fetch pointer SHALL reside in fetch_queue.

Verification
REQ-035 Reset release with imem_gnt=1 and rvalid one cycle after each grant, inst_ready=1: inst_pc sequence 0, 4, 8, 12 with matching rdata.
REQ-036 inst_ready=0 with an always-responding memory: exactly 4 entries accepted, then imem_req stays low; one pop lets exactly one new request issue.
REQ-037 Redirect to 32'h0000_0103 while a request to 8 is in WAIT: the response for 8 is dropped, the next imem_addr = 32'h0000_0100, and the queue is empty the cycle after the redirect.
REQ-038 Redirect in the same cycle as imem_rvalid and inst_ready with 2 entries queued: inst_valid goes low next cycle, no entry written, and the next request uses the redirect address.
REQ-039 Redirect to 32'hFFFF_FFFC with two grants: imem_addr 32'hFFFF_FFFC, then 32'h0000_0000.
REQ-040 Reset asserted in WAIT, then a late imem_rvalid after release: no queue write, and the first request after release uses RESET_PC.
